regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the register file's single write port between the in-order ALU writeback stage and the multi-cycle multiplier. It holds one multiplier result in a 1-entry buffer and arbitrates the write port each cycle, with ALU priority bounded by a starvation counter. It also keeps a per-register scoreboard of outstanding multiplies, so the pipeline can stall on RAW/WAW hazards. It sits between the writeback stage, the multiplier and the register file write port (reg_write/waddr/wdata).

## Interface
- DATA_W, 16, register data width
- MAX_WAIT, 4, max consecutive cycles a buffered multiplier result may lose arbitration (≥1)
- clk  in  1  system clock, all state on rising edge
- arst_n  in  1  reset, synchronous, active-low
- alu_we  in  1  ALU writeback request
- alu_waddr  in  5  ALU destination register
- alu_wdata  in  DATA_W  ALU result
- alu_stall  out  1  ALU request not accepted this cycle; writeback must hold
- mul_issue  in  1  multiply issued this cycle
- mul_issue_addr  in  5  destination of the issued multiply
- mul_valid  in  1  multiplier result valid
- mul_ready  out  1  buffer can accept a result
- mul_waddr  in  5  multiplier result destination
- mul_wdata  in  DATA_W  multiplier result
- raddr_1, raddr_2  in  5 each  decode-stage read addresses
- hz_1, hz_2  out  1 each  pending[raddr_x]; decode must stall
- pend_mask  out  32  scoreboard, bit i = multiply outstanding to x_i
- rf_reg_write  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  DATA_W  register file write data

## Operation
- State: buf_valid, buf_addr[4:0], buf_data[DATA_W-1:0], wait_cnt[$clog2(MAX_WAIT+1)-1:0], pending[31:0].
- Reset (arst_n low at an edge): buf_valid=0, wait_cnt=0, pending=0.
- While arst_n is low, the combinational outputs are forced to: rf_reg_write=0, mul_ready=0, alu_stall=0.
- mul_ready = ~buf_valid | grant_buf. This allows back-to-back results when the buffer drains in the same cycle.
- The buffer captures mul_waddr/mul_wdata when mul_valid & mul_ready.
- starve = buf_valid & (wait_cnt ≥ MAX_WAIT).
- waw = alu_we & pending[alu_waddr] & (alu_waddr≠0).
- grant_buf = buf_valid & (~alu_we | starve | waw).
- grant_alu = alu_we & ~grant_buf & ~waw.
- alu_stall = alu_we & ~grant_alu.
- The write port is driven from the winner: buf_addr/buf_data or alu_waddr/alu_wdata.
  - rf_reg_write = (grant_buf | grant_alu) & (winner address ≠ 0).
  - A write to x0 is consumed (grant taken, buffer drained) but not issued.
  - When there is no grant, rf_waddr and rf_wdata are 0.
- wait_cnt:
  - cleared on grant_buf or ~buf_valid;
  - otherwise incremented while buf_valid;
  - saturates at MAX_WAIT.
- Scoreboard next state:
  - pending[buf_addr] is cleared on grant_buf;
  - pending[mul_issue_addr] is set on mul_issue when mul_issue_addr≠0;
  - if set and clear hit the same index in the same cycle, set wins;
  - bit 0 is always 0.
- pend_mask = pending (registered).
- hz_x = pending[raddr_x], combinational from registered state.
- The multiplier completes in issue order. The decode stage guarantees no mul_issue to an address whose pending bit is set, because hz/waw stalls cover it.

## Timing
- Write-port latency: combinational. The register file writes at the same edge at which the grant occurs.
- Buffered result: captured at edge N, can write at the earliest at edge N+1.
- Worst-case buffer wait: MAX_WAIT lost cycles, then forced grant on the next cycle.
- Scoreboard:
  - mul_issue at cycle N makes the bit visible on pend_mask/hz from cycle N+1;
  - a grant_buf write at edge M clears the bit from cycle M+1.
  - Same-cycle decode read of a register being written is a register-file bypass concern, not handled here. hz stays 1 in that cycle.
- Simultaneous alu_we and buf_valid with no starve and no waw: ALU wins, wait_cnt+1.
- A reset mid-operation discards the buffered result and the scoreboard with no write. Outputs are in reset values from the cycle arst_n is low.

## Test plan
- Reset then idle: pend_mask=0, mul_ready=1, rf_reg_write=0. An ALU write of x5=0x1234 gives rf_reg_write=1, rf_waddr=5, rf_wdata=0x1234, alu_stall=0 in the same cycle.
- Issue mul to x7, result 0x00A0 arrives while the ALU is idle:
  - pend_mask[7]=1 the cycle after issue;
  - write of x7=0x00A0 one cycle after capture;
  - pend_mask[7]=0 afterwards; hz_1=1 while raddr_1=7 before that.
- Starvation, MAX_WAIT=4: buffered result with continuous alu_we. The ALU wins 4 cycles, then in the 5th cycle grant_buf=1 with alu_stall=1, and the ALU wins again the next cycle.
- WAW: pending[9]=1, ALU writes x9. alu_stall=1 until the buffered x9 write occurs, then the ALU x9 write goes the following cycle. Final x9 holds the ALU value.
- x0 handling: a mul_issue to x0 leaves pend_mask=0. A buffered x0 result drains with rf_reg_write=0 and mul_ready=1 in that cycle.
- Back-to-back and reset: a mul_valid held with the ALU idle accepts one result per cycle, with each written in order. Asserting arst_n low with buf_valid=1 and pending=0x80 gives no write and pend_mask=0 after the edge.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter between ALU writeback and a 1-entry multiplier result buffer,
// with bounded ALU priority and a per-register scoreboard of outstanding multiplies.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              alu_we,
  input  logic [4:0]        alu_waddr,
  input  logic [DATA_W-1:0] alu_wdata,
  output logic              alu_stall,
  input  logic              mul_issue,
  input  logic [4:0]        mul_issue_addr,
  input  logic              mul_valid,
  output logic              mul_ready,
  input  logic [4:0]        mul_waddr,
  input  logic [DATA_W-1:0] mul_wdata,
  input  logic [4:0]        raddr_1,
  input  logic [4:0]        raddr_2,
  output logic              hz_1,
  output logic              hz_2,
  output logic [31:0]       pend_mask,
  output logic              rf_reg_write,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(MAX_WAIT);

  logic              buf_valid_q, buf_valid_d;
  logic [4:0]        buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]       pending_q, pending_d;

  logic              starve;
  logic              waw;
  logic              grant_buf;
  logic              grant_alu;
  logic              capture;
  logic [4:0]        win_addr;
  logic [DATA_W-1:0] win_data;

  // Grants are gated by arst_n so every port-facing output idles while reset is held.
  always_comb begin
    starve    = buf_valid_q & (wait_cnt_q >= WAIT_LIM);
    waw       = alu_we & pending_q[alu_waddr] & (alu_waddr != 5'd0);
    grant_buf = arst_n & buf_valid_q & (~alu_we | starve | waw);
    grant_alu = arst_n & alu_we & ~grant_buf & ~waw;
    mul_ready = arst_n & (~buf_valid_q | grant_buf);
    alu_stall = arst_n & alu_we & ~grant_alu;
    capture   = mul_valid & mul_ready;

    win_addr = '0;
    win_data = '0;
    if (grant_buf) begin
      win_addr = buf_addr_q;
      win_data = buf_data_q;
    end else if (grant_alu) begin
      win_addr = alu_waddr;
      win_data = alu_wdata;
    end
    rf_reg_write = (grant_buf | grant_alu) & (win_addr != 5'd0);
    rf_waddr     = win_addr;
    rf_wdata     = win_data;

    hz_1      = pending_q[raddr_1];
    hz_2      = pending_q[raddr_2];
    pend_mask = pending_q;
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if (grant_buf) begin
      buf_valid_d = 1'b0;
    end
    if (capture) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = mul_waddr;
      buf_data_d  = mul_wdata;
    end

    if (grant_buf | ~buf_valid_q) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < WAIT_LIM) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    // Clear before set so a same-index issue in the drain cycle keeps the bit.
    pending_d = pending_q;
    if (grant_buf) begin
      pending_d[buf_addr_q] = 1'b0;
    end
    if (mul_issue && (mul_issue_addr != 5'd0)) begin
      pending_d[mul_issue_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      buf_valid_q <= 1'b0;
      wait_cnt_q  <= '0;
      pending_q   <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      wait_cnt_q  <= wait_cnt_d;
      pending_q   <= pending_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus randomized traffic, checked against a queue-based reference model.
module tb_regfile_wb_arbiter;
  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          alu_we;
  logic [4:0]    alu_waddr;
  logic [DW-1:0] alu_wdata;
  logic          alu_stall;
  logic          mul_issue;
  logic [4:0]    mul_issue_addr;
  logic          mul_valid;
  logic          mul_ready;
  logic [4:0]    mul_waddr;
  logic [DW-1:0] mul_wdata;
  logic [4:0]    raddr_1, raddr_2;
  logic          hz_1, hz_2;
  logic [31:0]   pend_mask;
  logic          rf_reg_write;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .arst_n(arst_n),
    .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata), .alu_stall(alu_stall),
    .mul_issue(mul_issue), .mul_issue_addr(mul_issue_addr),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_waddr(mul_waddr), .mul_wdata(mul_wdata),
    .raddr_1(raddr_1), .raddr_2(raddr_2), .hz_1(hz_1), .hz_2(hz_2), .pend_mask(pend_mask),
    .rf_reg_write(rf_reg_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: the waiting multiplier result is a queue of at most one entry.
  typedef struct { logic [4:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t           held[$];
  int            lost;
  bit            pend[32];
  logic [DW-1:0] rf_model[32];
  logic [DW-1:0] rf_seen[32];
  bit            e_buf_wins, e_alu_wins, e_stall, e_ready, e_we;
  logic [4:0]    e_addr;
  logic [DW-1:0] e_data;
  logic [4:0]    iq[$];

  function automatic void predict();
    bit starve, waw, has;
    e_buf_wins = 0; e_alu_wins = 0; e_stall = 0; e_ready = 0; e_we = 0;
    e_addr = '0; e_data = '0;
    if (!arst_n) return;
    has        = held.size() != 0;
    starve     = has && (lost >= MW);
    waw        = alu_we && (alu_waddr != 0) && pend[alu_waddr];
    e_buf_wins = has && (!alu_we || starve || waw);
    e_alu_wins = alu_we && !e_buf_wins && !waw;
    e_stall    = alu_we && !e_alu_wins;
    e_ready    = !has || e_buf_wins;
    if (e_buf_wins) begin e_addr = held[0].addr; e_data = held[0].data; end
    else if (e_alu_wins) begin e_addr = alu_waddr; e_data = alu_wdata; end
    e_we = (e_buf_wins || e_alu_wins) && (e_addr != 0);
  endfunction

  task automatic compare();
    logic [31:0] pm;
    predict();
    for (int i = 0; i < 32; i++) pm[i] = pend[i];
    check("rf_reg_write", rf_reg_write, e_we);
    check("rf_waddr", rf_waddr, e_addr);
    check("rf_wdata", rf_wdata, e_data);
    check("alu_stall", alu_stall, e_stall);
    check("mul_ready", mul_ready, e_ready);
    check("pend_mask", pend_mask, pm);
    check("hz_1", hz_1, pend[raddr_1]);
    check("hz_2", hz_2, pend[raddr_2]);
    if (rf_reg_write === 1'b1) rf_seen[rf_waddr] = rf_wdata;
  endtask

  task automatic update();
    wr_t w;
    if (!arst_n) begin
      held.delete();
      lost = 0;
      for (int i = 0; i < 32; i++) pend[i] = 0;
      return;
    end
    if (e_we) rf_model[e_addr] = e_data;
    if (e_buf_wins) begin
      pend[held[0].addr] = 0;
      void'(held.pop_front());
      lost = 0;
    end else if (held.size() != 0) begin
      if (lost < MW) lost++;
    end else lost = 0;
    if (mul_valid && e_ready) begin
      w.addr = mul_waddr; w.data = mul_wdata;
      held.push_back(w);
    end
    if (mul_issue && mul_issue_addr != 0) pend[mul_issue_addr] = 1;
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    update();
    #1;
  endtask

  initial begin
    arst_n = 0; alu_we = 0; alu_waddr = '0; alu_wdata = '0;
    mul_issue = 0; mul_issue_addr = '0; mul_valid = 0; mul_waddr = '0; mul_wdata = '0;
    raddr_1 = '0; raddr_2 = '0;
    lost = 0;
    for (int i = 0; i < 32; i++) begin rf_model[i] = '0; rf_seen[i] = '0; end

    step();
    #1 check("rst_ready", mul_ready, 1'b0);
    step();
    arst_n = 1;
    #1 check("idle_ready", mul_ready, 1'b1);
    check("idle_pend", pend_mask, 32'h0);
    check("idle_we", rf_reg_write, 1'b0);
    step();

    alu_we = 1; alu_waddr = 5; alu_wdata = 16'h1234;
    #1 check("x5_we", rf_reg_write, 1'b1);
    check("x5_addr", rf_waddr, 5);
    check("x5_data", rf_wdata, 16'h1234);
    check("x5_stall", alu_stall, 1'b0);
    step();
    alu_we = 0;

    mul_issue = 1; mul_issue_addr = 7;
    step();
    mul_issue = 0; raddr_1 = 7;
    #1 check("x7_pend", pend_mask[7], 1'b1);
    check("x7_hz", hz_1, 1'b1);
    mul_valid = 1; mul_waddr = 7; mul_wdata = 16'h00A0;
    step();
    mul_valid = 0;
    #1 check("x7_we", rf_reg_write, 1'b1);
    check("x7_addr", rf_waddr, 7);
    check("x7_data", rf_wdata, 16'h00A0);
    check("x7_hz_same", hz_1, 1'b1);
    step();
    #1 check("x7_clr", pend_mask[7], 1'b0);
    check("x7_hz_clr", hz_1, 1'b0);

    mul_issue = 1; mul_issue_addr = 3;
    step();
    mul_issue = 0;
    mul_valid = 1; mul_waddr = 3; mul_wdata = 16'hBEEF;
    alu_we = 1; alu_waddr = 4; alu_wdata = 16'h0400;
    step();
    mul_valid = 0;
    for (int k = 0; k < MW; k++) begin
      alu_wdata = DW'(16'h0401 + k);
      #1 check("starve_alu_stall", alu_stall, 1'b0);
      check("starve_alu_addr", rf_waddr, 4);
      step();
    end
    #1 check("starve_forced_stall", alu_stall, 1'b1);
    check("starve_forced_addr", rf_waddr, 3);
    check("starve_forced_data", rf_wdata, 16'hBEEF);
    step();
    #1 check("starve_after_stall", alu_stall, 1'b0);
    check("starve_after_addr", rf_waddr, 4);
    step();
    alu_we = 0;

    mul_issue = 1; mul_issue_addr = 9;
    step();
    mul_issue = 0;
    alu_we = 1; alu_waddr = 9; alu_wdata = 16'h5555;
    #1 check("waw_stall", alu_stall, 1'b1);
    check("waw_nowrite", rf_reg_write, 1'b0);
    step();
    step();
    mul_valid = 1; mul_waddr = 9; mul_wdata = 16'h9999;
    step();
    mul_valid = 0;
    #1 check("waw_buf_data", rf_wdata, 16'h9999);
    check("waw_buf_stall", alu_stall, 1'b1);
    step();
    #1 check("waw_alu_stall", alu_stall, 1'b0);
    check("waw_alu_data", rf_wdata, 16'h5555);
    step();
    alu_we = 0;
    check("waw_final", rf_seen[9], 16'h5555);

    mul_issue = 1; mul_issue_addr = 0;
    step();
    mul_issue = 0;
    #1 check("x0_pend", pend_mask, 32'h0);
    mul_valid = 1; mul_waddr = 0; mul_wdata = 16'h0077;
    step();
    mul_valid = 0;
    #1 check("x0_nowrite", rf_reg_write, 1'b0);
    check("x0_ready", mul_ready, 1'b1);
    step();

    for (int i = 0; i < 4; i++) begin
      mul_issue = 1; mul_issue_addr = 5'(10 + i);
      step();
    end
    mul_issue = 0;
    for (int i = 0; i < 4; i++) begin
      mul_valid = 1; mul_waddr = 5'(10 + i); mul_wdata = DW'(16'hB000 + i);
      #1 check("b2b_ready", mul_ready, 1'b1);
      if (i > 0) check("b2b_addr", rf_waddr, 10 + i - 1);
      step();
    end
    mul_valid = 0;
    #1 check("b2b_last", rf_waddr, 13);
    step();

    mul_issue = 1; mul_issue_addr = 7;
    step();
    mul_issue = 0;
    mul_valid = 1; mul_waddr = 7; mul_wdata = 16'h1111;
    alu_we = 1; alu_waddr = 2; alu_wdata = 16'h2222;
    step();
    mul_valid = 0; arst_n = 0;
    #1 check("rstmid_we", rf_reg_write, 1'b0);
    check("rstmid_stall", alu_stall, 1'b0);
    check("rstmid_ready", mul_ready, 1'b0);
    step();
    arst_n = 1; alu_we = 0;
    #1 check("rstmid_pend", pend_mask, 32'h0);
    check("rstmid_nowrite", rf_reg_write, 1'b0);
    check("rstmid_ready_after", mul_ready, 1'b1);
    step();

    // Random traffic obeying the decode-stage rules: no issue to a pending register,
    // in-order multiplier results, held requests while stalled / not ready.
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] a;
      arst_n = ($urandom_range(0, 199) != 0);
      mul_issue = 0;
      a = 5'($urandom);
      if (arst_n && $urandom_range(0, 2) == 0 && iq.size() < 4 && (a == 0 || !pend[a])) begin
        mul_issue = 1; mul_issue_addr = a;
      end
      if (!(alu_we && e_stall)) begin
        alu_we    = ($urandom_range(0, 9) < 6);
        alu_waddr = (iq.size() != 0 && $urandom_range(0, 3) == 0) ?
                    iq[$urandom_range(0, iq.size() - 1)] : 5'($urandom);
        alu_wdata = DW'($urandom);
      end
      if (!mul_valid && iq.size() != 0 && $urandom_range(0, 1) == 1) begin
        mul_valid = 1; mul_waddr = iq[0]; mul_wdata = DW'($urandom);
      end
      raddr_1 = 5'($urandom);
      raddr_2 = (iq.size() != 0) ? iq[0] : 5'($urandom);
      step();
      if (!arst_n) begin
        iq.delete();
        mul_valid = 0;
      end else begin
        if (mul_valid && e_ready) begin
          void'(iq.pop_front());
          mul_valid = 0;
        end
        if (mul_issue) iq.push_back(mul_issue_addr);
      end
    end
    arst_n = 1; alu_we = 0; mul_valid = 0; mul_issue = 0;
    step();

    for (int r = 1; r < 32; r++) check("rf_contents", rf_seen[r], rf_model[r]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
